// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for a 4-slot, active-low seven-segment
// display that shows three BCD digits.
// Slot 3 is always blank so that the three lit digits keep a 1/4 duty cycle.
// A new value is held in a shadow register and moves to the display only at the
// frame boundary, so a single scan never shows a mix of old and new digits.
// Optional feature: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading zeros
// in the hundreds and tens digits.
module seven_seg_scan #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DIV_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd,
    input  logic        bcd_valid,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] cnt;
    logic [1:0]       idx;
    logic [11:0]      shadow;
    logic [11:0]      disp;
    logic             tick;
    logic             boundary;
    logic [3:0]       nib;
    logic             blank;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show '-'.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    assign tick     = (cnt == DIV_LAST);
    assign boundary = tick && (idx == 2'd3);
    assign dp       = 1'b1;

    // Prescaler: counts 0..REFRESH_DIV-1 and wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // Digit index advances once per prescaler period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // Shadow captures every strobe; the display loads at the frame boundary,
    // bypassing the shadow when a strobe lands on the boundary edge itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            disp   <= '0;
            frame  <= 1'b0;
        end else begin
            if (bcd_valid) begin
                shadow <= bcd;
            end
            if (boundary) begin
                disp <= bcd_valid ? bcd : shadow;
            end
            frame <= boundary;
        end
    end

    // Select the nibble for the current slot and decide whether it is blanked.
    always_comb begin
        nib     = '0;
        blank   = 1'b0;
        an_nxt  = '1;
        seg_nxt = '1;
        case (idx)
            2'd0:    nib = disp[3:0];
            2'd1:    nib = disp[7:4];
            2'd2:    nib = disp[11:8];
            default: blank = 1'b1;
        endcase
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (idx == 2'd2 && disp[11:8] == 4'd0) begin
            blank = 1'b1;
        end
        if (idx == 2'd1 && disp[11:4] == 8'd0) begin
            blank = 1'b1;
        end
`else
`endif
        if (!blank) begin
            an_nxt[idx] = 1'b0;
            seg_nxt     = seg_decode(nib);
        end
    end

    // Registered anode and segment outputs, dark during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= '1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed bench for seven_seg_scan with REFRESH_DIV=4.
// Outputs are sampled on the falling clock edge; cyc counts rising edges since
// the most recent reset release.
module tb_seven_seg_scan;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] SDASH = 7'b0111111;
    localparam logic [6:0] SOFF  = 7'b1111111;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] bcd = '0;
    logic        bcd_valid = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seven_seg_scan #(
        .REFRESH_DIV(4),
        .DIV_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bcd(bcd),
        .bcd_valid(bcd_valid),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
        chk({tag, "_an"}, {8'h0, an}, {8'h0, an_e});
        chk({tag, "_seg"}, {5'h0, seg}, {5'h0, seg_e});
    endtask

    // Advance to the falling edge that follows rising edge number 'target'.
    task automatic go_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        chk_slot("rst_async", 4'b1111, SOFF);
        chk("rst_dp", {11'h0, dp}, 12'h001);
        chk("rst_frame", {11'h0, frame}, 12'h000);
        repeat (3) @(negedge clk);
        chk_slot("rst_held", 4'b1111, SOFF);
        rst = 1'b0;
        cyc = 0;

        // Free-running scan of the cleared value 000
        go_to(1);
        chk_slot("d0_first", 4'b1110, S0);
        go_to(4);
        chk_slot("d0_last", 4'b1110, S0);
        go_to(5);
        chk_slot("d1", LZB ? 4'b1111 : 4'b1101, LZB ? SOFF : S0);
        go_to(9);
        chk_slot("d2", LZB ? 4'b1111 : 4'b1011, LZB ? SOFF : S0);
        go_to(13);
        chk_slot("d3_blank", 4'b1111, SOFF);
        go_to(15);
        chk("frame_pre", {11'h0, frame}, 12'h000);
        go_to(16);
        chk("frame_16", {11'h0, frame}, 12'h001);
        go_to(17);
        chk("frame_post", {11'h0, frame}, 12'h000);
        chk_slot("wrap_d0", 4'b1110, S0);

        // Mid-frame strobe of 255 is held until the frame boundary
        go_to(20);
        bcd = 12'h255; bcd_valid = 1'b1;
        go_to(21);
        bcd_valid = 1'b0;
        go_to(28);
        chk_slot("old_d2", LZB ? 4'b1111 : 4'b1011, LZB ? SOFF : S0);
        go_to(32);
        chk("frame_32", {11'h0, frame}, 12'h001);
        go_to(33);
        chk_slot("v255_d0", 4'b1110, S5);
        go_to(37);
        chk_slot("v255_d1", 4'b1101, S5);
        go_to(41);
        chk_slot("v255_d2", 4'b1011, S2);
        go_to(45);
        chk_slot("v255_d3", 4'b1111, SOFF);

        // Two strobes in one frame: only the later one is displayed
        go_to(49);
        bcd = 12'h123; bcd_valid = 1'b1;
        go_to(50);
        bcd_valid = 1'b0;
        go_to(53);
        chk_slot("hold_d1", 4'b1101, S5);
        go_to(54);
        bcd = 12'h045; bcd_valid = 1'b1;
        go_to(55);
        bcd_valid = 1'b0;
        go_to(57);
        chk_slot("hold_d2", 4'b1011, S2);
        go_to(65);
        chk_slot("v045_d0", 4'b1110, S5);
        go_to(69);
        chk_slot("v045_d1", 4'b1101, S4);
        go_to(73);
        chk_slot("v045_d2", LZB ? 4'b1111 : 4'b1011, LZB ? SOFF : S0);

        // Strobe of 007 coinciding with the frame-boundary edge (edge 80)
        go_to(79);
        bcd = 12'h007; bcd_valid = 1'b1;
        go_to(80);
        bcd_valid = 1'b0;
        chk("frame_80", {11'h0, frame}, 12'h001);
        go_to(81);
        chk_slot("v007_d0", 4'b1110, S7);
        go_to(85);
        chk_slot("v007_d1", LZB ? 4'b1111 : 4'b1101, LZB ? SOFF : S0);
        go_to(89);
        chk_slot("v007_d2", LZB ? 4'b1111 : 4'b1011, LZB ? SOFF : S0);

        // Non-decimal nibbles show a dash
        bcd = 12'hA3F; bcd_valid = 1'b1;
        go_to(90);
        bcd_valid = 1'b0;
        go_to(97);
        chk_slot("vA3F_d0", 4'b1110, SDASH);
        go_to(101);
        chk_slot("vA3F_d1", 4'b1101, S3);
        go_to(105);
        chk_slot("vA3F_d2", 4'b1011, SDASH);

        // Reset during digit 2 with a pending strobe discards it
        go_to(102 > cyc ? 102 : cyc);
        bcd = 12'h999; bcd_valid = 1'b1;
        go_to(106);
        bcd_valid = 1'b0;
        chk_slot("pre_rst_d2", 4'b1011, SDASH);
        rst = 1'b1;
        #1;
        chk_slot("rst_mid", 4'b1111, SOFF);
        chk("rst_mid_frame", {11'h0, frame}, 12'h000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        go_to(1);
        chk_slot("rs_d0", 4'b1110, S0);
        go_to(5);
        chk_slot("rs_d1", LZB ? 4'b1111 : 4'b1101, LZB ? SOFF : S0);
        go_to(9);
        chk_slot("rs_d2", LZB ? 4'b1111 : 4'b1011, LZB ? SOFF : S0);
        go_to(16);
        chk("rs_frame_16", {11'h0, frame}, 12'h001);
        go_to(17);
        chk_slot("rs_after_frame", 4'b1110, S0);
        go_to(25);
        chk_slot("rs_after_frame_d2", LZB ? 4'b1111 : 4'b1011, LZB ? SOFF : S0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
